// File: rtl/riscv_pkg.sv
// Shared MiniRiscV constants used by the fetch stage.
package riscv_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam int          PC_STEP      = 4;
endpackage

// File: rtl/ifetch_fifo.sv
// Fetch queue: circular buffer of {inst, pc} entries with wrap-bit pointers.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop, do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full queue is fine when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/ifetch_unit.sv
// MiniRiscV instruction fetch: PC, credit-limited ROM issue, fetch queue, redirect flush.
// Define IFETCH_PERF_EN to add pop/redirect performance counters.
module ifetch_unit import riscv_pkg::*; #(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              ADDR_W   = 14,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_inst,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_pc_plus4
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, resp_pc_q;
    logic            resp_vld_q, resp_epoch_q, epoch_q;
    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic            full, empty, push, pop, credit;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic            unused;

    assign unused = ^redirect_pc[1:0];

    // Credit counts the outstanding read too, so a response always has a slot.
    assign used     = {1'b0, count} + {{CW{1'b0}}, resp_vld_q};
    assign credit   = ~full & (used < (CW+1)'(FQ_DEPTH));
    assign imem_req = rst & ~redirect_valid & credit;
    assign imem_addr = pc_q[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            epoch_q      <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_pc_q    <= '0;
            resp_epoch_q <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_q    <= {redirect_pc[XLEN-1:2], 2'b00};
                epoch_q <= ~epoch_q;
            end else if (imem_req) begin
                pc_q    <= pc_q + XLEN'(PC_STEP);
            end
            resp_vld_q   <= imem_req;
            resp_pc_q    <= pc_q;
            resp_epoch_q <= epoch_q;
        end
    end

    // Responses from an older epoch, or arriving during a redirect, are stale.
    assign push = resp_vld_q & (resp_epoch_q == epoch_q) & ~redirect_valid;
    assign pop  = if_valid & if_ready;

    ifetch_fifo #(.DEPTH(FQ_DEPTH), .W(32 + XLEN)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rdata, resp_pc_q}),
        .rdata ({head_inst, head_pc}),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign if_valid    = rst & ~empty & ~redirect_valid;
    assign if_inst     = if_valid ? head_inst : INST_NOP;
    assign if_pc       = head_pc;
    assign if_pc_plus4 = head_pc + XLEN'(PC_STEP);

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a PC-stream scoreboard; two instances
// (RESET_PC 0 and FFFF_FFFC) share stimulus.
module tb_ifetch_unit;
    localparam int XLEN = 32, ADDR_W = 14, FQ = 4;

    logic              clk = 1'b0, rst = 1'b0;
    logic              redirect_valid = 1'b0, if_ready = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              imem_req, imem_req_w, if_valid, if_valid_w;
    logic [ADDR_W-1:0] imem_addr, imem_addr_w;
    logic [31:0]       imem_rdata, imem_rdata_w, if_inst, if_inst_w;
    logic [XLEN-1:0]   if_pc, if_pc_w, if_pc_plus4, if_pc_plus4_w;
`ifdef IFETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt, perf_flush_cnt, perf_fetch_cnt_w, perf_flush_cnt_w;
`endif

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    ifetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .if_valid(if_valid_w), .if_ready(if_ready), .if_inst(if_inst_w),
        .if_pc(if_pc_w), .if_pc_plus4(if_pc_plus4_w)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt_w), .perf_flush_cnt(perf_flush_cnt_w)
`endif
    );

    // ROM[i] = i, one-cycle latency; junk when no read was issued.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? {18'b0, imem_addr}   : 32'hBAD0_0BAD;
        imem_rdata_w <= imem_req_w ? {18'b0, imem_addr_w} : 32'hBAD0_0BAD;
    end

    int vectors = 0, miscompares = 0;
    logic [31:0] exp_pc, exp_req, exp_w;
    int since, n_pops, n_flush;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, sample at the falling edge, advance the model.
    task automatic tick(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
        @(negedge clk);
        if (!rst) begin
            check("rst_req", {31'b0, imem_req}, 0);
            check("rst_valid", {31'b0, if_valid}, 0);
            exp_pc = 32'h0; exp_req = 32'h0; exp_w = 32'hFFFF_FFFC;
            since = 0; n_pops = 0; n_flush = 0;
        end else begin
            since++;
`ifdef IFETCH_PERF_EN
            check("perf_fetch", perf_fetch_cnt, n_pops);
            check("perf_flush", perf_flush_cnt, n_flush);
`endif
            if (imem_req) begin
                check("req_addr", {18'b0, imem_addr}, {18'b0, exp_req[15:2]});
                exp_req += 4;
            end
            check("credit", {31'b0, ((exp_req - exp_pc) >> 2) <= FQ}, 1);
            if (rv) begin
                check("redir_req", {31'b0, imem_req}, 0);
                check("redir_valid", {31'b0, if_valid}, 0);
            end else if (since == 1 || since == 2) begin
                check("lat_gap", {31'b0, if_valid}, 0);
            end else if (since == 3) begin
                check("lat_first", {31'b0, if_valid}, 1);
            end
            if (if_valid && rdy) begin
                check("pc", if_pc, exp_pc);
                check("inst", if_inst, {18'b0, exp_pc[15:2]});
                check("pc_plus4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc += 4; n_pops++;
            end
            if (if_valid_w && rdy) begin
                check("w_pc", if_pc_w, exp_w);
                check("w_inst", if_inst_w, {18'b0, exp_w[15:2]});
                check("w_pc_plus4", if_pc_plus4_w, exp_w + 32'd4);
                exp_w += 4;
            end
            if (rv) begin
                exp_pc = {rpc[31:2], 2'b00}; exp_req = exp_pc; exp_w = exp_pc;
                since = 0; n_flush++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
    endtask

    initial begin
        logic        rv, rdy;
        logic [31:0] rpc;
        @(posedge clk); #1;

        // Reset, streaming with if_ready=1; the wrap instance crosses 2^32.
        do_reset(2);
        repeat (12) tick(1'b0, 32'h0, 1'b1);

        // Stall decode: queue fills, issue stops, nothing lost on release.
        repeat (10) tick(1'b0, 32'h0, 1'b0);
        check("stall_req", {31'b0, imem_req}, 0);
        check("stall_valid", {31'b0, if_valid}, 1);
        check("stall_outstanding", (exp_req - exp_pc) >> 2, FQ);

        // Redirect with a full queue.
        tick(1'b1, 32'h40, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        check("redir_head_valid", {31'b0, if_valid}, 1);
        check("redir_head_pc", if_pc, 32'h40);
        repeat (6) tick(1'b0, 32'h0, 1'b1);

        // Redirect one cycle after reset; low bits of the target ignored.
        do_reset(1);
        tick(1'b1, 32'h43, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        check("misalign_pc", if_pc, 32'h40);
        repeat (5) tick(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: last one wins.
        tick(1'b1, 32'h80, 1'b1);
        tick(1'b1, 32'hC0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        check("b2b_pc", if_pc, 32'hC0);
        repeat (5) tick(1'b0, 32'h0, 1'b1);

        // Single-cycle reset mid-stream.
        do_reset(1);
        repeat (8) tick(1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                rv  = ($urandom_range(0, 19) == 0);
                rpc = $urandom;
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
                rdy = ($urandom_range(0, 3) != 0);
                tick(rv, rpc, rdy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
